// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: iterative AES-128 key expander, one round key per clock, stored for random-access reads.
// Optional zeroize port enabled by defining AES_KEYSCHED_ZEROIZE_EN.
module aes_key_schedule_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter bit RD_REG     = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_out,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`ifdef AES_KEYSCHED_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_schedule_seq: NUM_ROUNDS must be 10");
    end

    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   store_q [0:10];
    logic [127:0]   cur_q, cur_d, rk_out_q, rk_out_d, wr_data, nk, rd_c;
    logic [3:0]     rk_index_q, rk_index_d, round_q, round_d, wr_idx;
    logic           rk_valid_q, rk_valid_d, busy_q, busy_d, ready_q, ready_d, wr_en, zero;
    logic [7:0]     rc;

`ifdef AES_KEYSCHED_ZEROIZE_EN
    assign zero = zeroize;
`else
    assign zero = 1'b0;
`endif

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] w, input logic [7:0] r);
        logic [31:0] t, a, b, c, d;
        t = {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])} ^ {r, 24'h0};
        a = w[127:96] ^ t;
        b = w[95:64] ^ a;
        c = w[63:32] ^ b;
        d = w[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    // RCON doubles for rounds 1..8, then wraps through the GF(2^8) reduction
    assign rc = (round_q <= 4'd8) ? 8'h01 << (round_q - 4'd1) : (round_q == 4'd9 ? 8'h1b : 8'h36);
    assign nk = next_key(cur_q, rc);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rk_out_d   = rk_out_q;
        rk_index_d = rk_index_q;
        rk_valid_d = 1'b0;
        busy_d     = busy_q;
        ready_d    = ready_q;
        round_d    = round_q;
        wr_en      = 1'b0;
        wr_idx     = round_q;
        wr_data    = nk;
        if (zero) begin
            state_d    = IDLE;
            cur_d      = '0;
            rk_out_d   = '0;
            rk_index_d = '0;
            busy_d     = 1'b0;
            ready_d    = 1'b0;
            round_d    = '0;
        end else if (state_q == EXPAND) begin
            wr_en      = 1'b1;
            cur_d      = nk;
            rk_out_d   = nk;
            rk_index_d = round_q;
            rk_valid_d = 1'b1;
            round_d    = round_q + 4'd1;
            if (round_q == 4'(NUM_ROUNDS)) begin
                state_d = DONE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end else if (key_load) begin
            state_d    = EXPAND;
            wr_en      = 1'b1;
            wr_idx     = 4'd0;
            wr_data    = key_in;
            cur_d      = key_in;
            rk_out_d   = key_in;
            rk_index_d = 4'd0;
            rk_valid_d = 1'b1;
            busy_d     = 1'b1;
            ready_d    = 1'b0;
            round_d    = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            rk_out_q   <= '0;
            rk_index_q <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rk_out_q   <= rk_out_d;
            rk_index_q <= rk_index_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            round_q    <= round_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || zero) begin
            for (int i = 0; i < 11; i++) store_q[i] <= '0;
        end else if (wr_en) begin
            store_q[wr_idx] <= wr_data;
        end
    end

    assign rd_c = (rd_idx <= 4'd10) ? store_q[rd_idx] : '0;

    if (RD_REG) begin : g_rd_reg
        logic [127:0] rd_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rd_q <= '0;
            else     rd_q <= rd_c;
        end
        assign rd_key = rd_q;
    end else begin : g_rd_comb
        assign rd_key = rd_c;
    end

    assign busy       = busy_q;
    assign keys_ready = ready_q;
    assign rk_valid   = rk_valid_q;
    assign rk_index   = rk_index_q;
    assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: directed checks of the AES-128 key expander against FIPS-197 round keys.
module tb_aes_key_schedule_seq;
  logic clk = 1'b0;
  logic rst, key_load;
  logic [127:0] key_in;
  logic [3:0] rd_idx;
  logic busy, keys_ready, rk_valid, busy1, ready1, valid1;
  logic [3:0] rk_index, index1;
  logic [127:0] rk_out, rd_key, out1, rd_key1;
  int total = 0, bad = 0, nv;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1K [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] Z1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  always #5 clk = ~clk;
  aes_key_schedule_seq #(.NUM_ROUNDS(10), .RD_REG(1'b0)) u0 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy), .keys_ready(keys_ready), .rk_valid(rk_valid), .rk_index(rk_index),
    .rk_out(rk_out), .rd_idx(rd_idx), .rd_key(rd_key)
`ifdef AES_KEYSCHED_ZEROIZE_EN
    , .zeroize(zeroize)
`endif
  );
  aes_key_schedule_seq #(.NUM_ROUNDS(10), .RD_REG(1'b1)) u1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy1), .keys_ready(ready1), .rk_valid(valid1), .rk_index(index1),
    .rk_out(out1), .rd_idx(rd_idx), .rd_key(rd_key1)
`ifdef AES_KEYSCHED_ZEROIZE_EN
    , .zeroize(zeroize)
`endif
  );
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask
  initial begin
    logic [127:0] exp;
    rst = 1'b1; key_load = 1'b0; key_in = '0; rd_idx = '0;
    step(); step();
    chk("rst_busy", busy === 1'b0);
    chk("rst_ready", keys_ready === 1'b0);
    chk("rst_valid", rk_valid === 1'b0);
    chk("rst_index", rk_index === 4'd0);
    chk("rst_rk", rk_out === 128'h0);
    chk("rst_rd0", rd_key === 128'h0);
    chk("rst_rd1", rd_key1 === 128'h0);
    rst = 1'b0;
    step();
    key_in = K1; key_load = 1'b1;
    step();
    key_load = 1'b0;
    nv = int'(rk_valid);
    chk("t1_e0_rk", rk_out === K1);
    chk("t1_e0_idx", rk_index === 4'd0);
    chk("t1_e0_busy", busy === 1'b1);
    chk("t1_e0_ready", keys_ready === 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      nv += int'(rk_valid);
      chk("t1_rk", rk_out === R1K[k]);
      chk("t1_idx", rk_index === 4'(k));
    end
    chk("t1_busy_done", busy === 1'b0);
    chk("t1_ready", keys_ready === 1'b1);
    step();
    chk("t1_e11_valid", rk_valid === 1'b0);
    chk("t1_hold_rk", rk_out === R1K[10]);
    chk("t1_hold_idx", rk_index === 4'd10);
    chk("t1_valid_count", nv == 11);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      exp = (i <= 10) ? R1K[i] : 128'h0;
      #1;
      chk("t2_rd_comb", rd_key === exp);
      step();
      chk("t2_rd_reg", rd_key1 === exp);
    end
    rd_idx = 4'd5; key_in = '0; key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("t4_ready_fall", keys_ready === 1'b0);
    chk("t4_busy", busy === 1'b1);
    chk("t4_e0_rk", rk_out === 128'h0);
    step();
    chk("t4_idx1", rk_out === Z1);
    chk("t4_old_rd5", rd_key === R1K[5]);
    repeat (9) step();
    chk("t4_idx10", rk_out === Z10);
    chk("t4_index10", rk_index === 4'd10);
    chk("t4_ready", keys_ready === 1'b1);
    key_in = K1; key_load = 1'b1;
    step();
    key_load = 1'b0;
    repeat (3) step();
    key_in = '0; key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("t3_e4_rk", rk_out === R1K[4]);
    chk("t3_e4_idx", rk_index === 4'd4);
    repeat (6) step();
    chk("t3_idx10", rk_out === R1K[10]);
    chk("t3_ready", keys_ready === 1'b1);
    rd_idx = 4'd0;
    #1;
    chk("t3_rd0", rd_key === K1);
    key_in = K1; key_load = 1'b1;
    step();
    key_load = 1'b0;
    repeat (5) step();
    #3;
    rst = 1'b1;
    #1;
    chk("t5_busy", busy === 1'b0);
    chk("t5_valid", rk_valid === 1'b0);
    chk("t5_rk", rk_out === 128'h0);
    chk("t5_idx", rk_index === 4'd0);
    chk("t5_ready", keys_ready === 1'b0);
    chk("t5_rd_reg", rd_key1 === 128'h0);
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("t5_rd_clear", rd_key === 128'h0);
    end
    step();
    rst = 1'b0;
    step();
    chk("t5_idle_busy", busy === 1'b0);
    chk("t5_idle_ready", keys_ready === 1'b0);
    chk("t5_idle_valid", rk_valid === 1'b0);
    key_in = K1; key_load = 1'b1;
    step();
    key_load = 1'b0;
    step();
    chk("t5_idx1", rk_out === R1K[1]);
    repeat (9) step();
    chk("t5_idx10", rk_out === R1K[10]);
    chk("t5_ready_again", keys_ready === 1'b1);
`ifdef AES_KEYSCHED_ZEROIZE_EN
    zeroize = 1'b1; key_load = 1'b1; key_in = K1;
    step();
    zeroize = 1'b0; key_load = 1'b0;
    chk("t6_ready", keys_ready === 1'b0);
    chk("t6_busy", busy === 1'b0);
    chk("t6_valid", rk_valid === 1'b0);
    chk("t6_rk", rk_out === 128'h0);
    step();
    chk("t6_no_start", busy === 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("t6_rd_clear", rd_key === 128'h0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
